fc_layer: RTL and testbench

FC_LAYER -- requirements
Module: fc_layer

---
 rtl/fc_layer_pkg.sv | 58 +++++
 rtl/fc_layer_mac.sv | 41 ++++
 rtl/fc_layer.sv | 141 ++++++++++++++
 tb/tb_fc_layer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fc_layer_pkg.sv
// Shared constants, FSM state type and result finalisation for the FC layer.
// Covers the Q4.16 widths, the memory select codes, the rounding offset and
// the saturation limits used when a neuron result is written back.
package fc_layer_pkg;

  localparam int DATA_W = 20;              // Q4.16 word
  localparam int FRAC_W = 16;              // fractional bits
  localparam int PROD_W = 2 * DATA_W;      // full-precision product
  localparam int ACC_W  = 52;              // accumulator width
  localparam int SUM_W  = ACC_W + 1;       // acc + bias + round, one guard bit
  localparam int SHR_W  = SUM_W - FRAC_W;  // width after dropping fraction

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L2   = 3'b101;  // flattened layer (read)
  localparam logic [2:0] CSEL_L3   = 3'b110;  // FC result layer (write)

  localparam logic [SUM_W-1:0]  RND_OFS = SUM_W'(32'h8000);
  localparam logic [DATA_W-1:0] SAT_MAX = 20'h7FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 20'h80000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } fc_state_t;

  // acc + (bias << 16) + 0x8000, arithmetic shift right by 16, saturate to a
  // 20-bit signed word, then optionally clamp negatives to zero.
  function automatic logic [DATA_W-1:0] fc_finalize(
    input logic [ACC_W-1:0]  acc,
    input logic [DATA_W-1:0] bias,
    input logic              relu
  );
    logic [SUM_W-1:0]  w_sum;
    logic [SHR_W-1:0]  w_shr;
    logic [DATA_W-1:0] w_res;
    w_sum = {acc[ACC_W-1], acc}
          + ({{(SUM_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_W)
          + RND_OFS;
    // Taking the upper bits of a two's complement sum is the arithmetic shift.
    w_shr = SHR_W'(w_sum >> FRAC_W);
    // Out of range when the bits above the 20-bit sign bit disagree with it.
    if (!w_shr[SHR_W-1] && (|w_shr[SHR_W-2:DATA_W-1])) begin
      w_res = SAT_MAX;
    end else if (w_shr[SHR_W-1] && !(&w_shr[SHR_W-2:DATA_W-1])) begin
      w_res = SAT_MIN;
    end else begin
      w_res = w_shr[DATA_W-1:0];
    end
    if (relu && w_res[DATA_W-1]) begin
      w_res = '0;
    end
    return w_res;
  endfunction

endpackage

// File: rtl/fc_layer_mac.sv
// fc_mac: registered signed 20x20 multiplier feeding a 52-bit accumulator.
// Ports: clk/reset; i_clr clears the accumulator; i_en marks i_a/i_b valid;
// o_acc is the running sum, updated two cycles after the operands arrive.
module fc_mac
  import fc_layer_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [PROD_W-1:0] r_prod;
  logic                     r_prod_vld;
  logic signed [ACC_W-1:0]  r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_prod_vld <= i_en;
      if (i_en) begin
        r_prod <= PROD_W'(i_a) * PROD_W'(i_b);
      end
      // Clear only ever coincides with an empty pipeline; it still wins.
      if (i_clr) begin
        r_acc <= '0;
      end else if (r_prod_vld) begin
        r_acc <= r_acc + ACC_W'(r_prod);
      end
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fc_layer.sv
// fc_layer: fully connected layer; one neuron per pass of N_IN reads, a
// 3-cycle drain and a single result write, N_IN+4 cycles per neuron.
// Ports: start/busy/done handshake, layer-memory read (crd, caddr_rd,
// cdata_rd), weight and bias ROMs (waddr/wdata, baddr/bdata), result write
// (cwr, caddr_wr, cdata_wr) and the memory select csel.
module fc_layer
  import fc_layer_pkg::*;
#(
  parameter int N_IN  = 2048,
  parameter int N_OUT = 10,
  parameter int RELU  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic [14:0] waddr,
  input  logic [19:0] wdata,
  output logic [3:0]  baddr,
  input  logic [19:0] bdata,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel
);

  localparam logic [11:0] LAST_I = 12'(N_IN - 1);
  localparam logic [3:0]  LAST_O = 4'(N_OUT - 1);

  fc_state_t   r_state;
  fc_state_t   w_next;
  logic [11:0] r_i;
  logic [3:0]  r_o;
  logic [1:0]  r_dcnt;

  logic                     r_rd_d1;   // read data on the ports this cycle
  logic                     r_bcap;    // bias data on the port this cycle
  logic                     r_dat_vld;
  logic signed [DATA_W-1:0] r_dat;
  logic signed [DATA_W-1:0] r_wgt;
  logic [DATA_W-1:0]        r_bias;

  logic                     w_fetch;
  logic                     w_write;
  logic                     w_clr;
  logic signed [ACC_W-1:0]  w_acc;
  logic [DATA_W-1:0]        w_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start)              w_next = ST_FETCH;
      ST_FETCH: if (r_i == LAST_I)      w_next = ST_DRAIN;
      ST_DRAIN: if (r_dcnt == 2'd2)     w_next = ST_WRITE;
      ST_WRITE: w_next = (r_o == LAST_O) ? ST_DONE : ST_FETCH;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Counters return to zero at the end of each phase so the next neuron (or
  // the next pass) starts from index 0 without an extra clear cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_i    <= '0;
      r_o    <= '0;
      r_dcnt <= '0;
    end else begin
      case (r_state)
        ST_FETCH: r_i    <= (r_i == LAST_I) ? 12'd0 : r_i + 12'd1;
        ST_DRAIN: r_dcnt <= (r_dcnt == 2'd2) ? 2'd0 : r_dcnt + 2'd1;
        ST_WRITE: if (r_o != LAST_O) r_o <= r_o + 4'd1;
        ST_DONE:  r_o    <= '0;
        default:  ;
      endcase
    end
  end

  // Memories return data one cycle after the address; capture it here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_d1   <= 1'b0;
      r_bcap    <= 1'b0;
      r_dat_vld <= 1'b0;
      r_dat     <= '0;
      r_wgt     <= '0;
      r_bias    <= '0;
    end else begin
      r_rd_d1   <= w_fetch;
      r_bcap    <= w_fetch && (r_i == 12'd0);
      r_dat_vld <= r_rd_d1;
      if (r_rd_d1) begin
        r_dat <= cdata_rd;
        r_wgt <= wdata;
      end
      if (r_bcap) begin
        r_bias <= bdata;
      end
    end
  end

  assign w_fetch = (r_state == ST_FETCH);
  assign w_write = (r_state == ST_WRITE);
  assign w_clr   = (w_next == ST_FETCH) && (r_state != ST_FETCH);

  fc_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (r_dat_vld),
    .i_a   (r_dat),
    .i_b   (r_wgt),
    .o_acc (w_acc)
  );

  assign w_result = fc_finalize(w_acc, r_bias, RELU != 0);

  assign busy     = w_fetch || (r_state == ST_DRAIN) || w_write;
  assign done     = (r_state == ST_DONE);
  assign crd      = w_fetch;
  assign caddr_rd = w_fetch ? r_i : 12'd0;
  assign waddr    = w_fetch ? (15'(r_o) * 15'(N_IN) + 15'(r_i)) : 15'd0;
  assign baddr    = r_o;
  assign cwr      = w_write;
  assign caddr_wr = w_write ? {8'd0, r_o} : 12'd0;
  assign cdata_wr = w_write ? w_result : 20'd0;
  assign csel     = w_fetch ? CSEL_L2 : (w_write ? CSEL_L3 : CSEL_NONE);

endmodule

// File: tb/tb_fc_layer.sv
// Testbench for fc_layer: four instances with different N_IN/N_OUT/RELU share
// one set of registered memory models; directed vectors plus control sequences.
module tb_fc_layer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  start_v = 4'b0;
  wire  [3:0]  busy_v, done_v, crd_v, cwr_v;
  wire  [11:0] cra  [4];
  wire  [14:0] wa   [4];
  wire  [3:0]  ba   [4];
  wire  [11:0] cwa  [4];
  wire  [19:0] cdat [4];
  wire  [2:0]  csl  [4];
  logic [19:0] cd [4];
  logic [19:0] wd [4];
  logic [19:0] bd [4];

  logic [19:0] mem_d [16];
  logic [19:0] mem_w [16];
  logic [19:0] mem_b [16];

  // instance g: 0=(4,2,relu) 1=(1,1,relu) 2=(1,1,signed) 3=(4,1,signed)
  for (genvar g = 0; g < 4; g++) begin : g_dut
    fc_layer #(
      .N_IN  ((g == 0 || g == 3) ? 4 : 1),
      .N_OUT ((g == 0) ? 2 : 1),
      .RELU  ((g < 2) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start_v[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .crd      (crd_v[g]),
      .caddr_rd (cra[g]),
      .cdata_rd (cd[g]),
      .waddr    (wa[g]),
      .wdata    (wd[g]),
      .baddr    (ba[g]),
      .bdata    (bd[g]),
      .cwr      (cwr_v[g]),
      .caddr_wr (cwa[g]),
      .cdata_wr (cdat[g]),
      .csel     (csl[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered memories: data valid the cycle after the address.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      cd[k] <= mem_d[cra[k][3:0]];
      wd[k] <= mem_w[wa[k][3:0]];
      bd[k] <= mem_b[ba[k]];
    end
  end

  int          wr_cnt [4] = '{0, 0, 0, 0};
  logic [19:0] wr_dat [4][2];
  int          n_ovl = 0;
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (cwr_v[k]) begin
        wr_dat[k][cwa[k][0]] <= cdat[k];
        wr_cnt[k] <= wr_cnt[k] + 1;
      end
      if (crd_v[k] && cwr_v[k]) n_ovl <= n_ovl + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic int nin_of(input int k);
    return (k == 0 || k == 3) ? 4 : 1;
  endfunction

  typedef struct packed {
    int               k;
    int               n;
    logic [3:0][19:0] d;
    logic [7:0][19:0] w;
    logic [1:0][19:0] b;
    logic [1:0][19:0] e;
  } vec_t;

  function automatic vec_t mk(input int k, input int n, input logic [79:0] d,
                              input logic [159:0] w, input logic [39:0] b,
                              input logic [39:0] e);
    vec_t v;
    v.k = k; v.n = n; v.d = d; v.w = w; v.b = b; v.e = e;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int j = 0; j < 16; j++) begin
      mem_d[j] = (j < 4) ? v.d[j] : 20'h0;
      mem_w[j] = (j < 8) ? v.w[j] : 20'h0;
      mem_b[j] = (j < 2) ? v.b[j] : 20'h0;
    end
  endtask

  // Starts a pass at the current negedge; returns start-to-done cycles and
  // busy-rise-to-done cycles (-1 if done never came within the budget).
  task automatic run_pass(input int k, input bit extra, output int lat, output int b2d);
    int c0;
    int bfirst;
    c0 = cyc;
    bfirst = -1;
    lat = -1;
    start_v[k] = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      start_v[k] = (extra && n == 4);
      if (busy_v[k] && bfirst < 0) bfirst = cyc;
      if (done_v[k]) begin
        lat = cyc - c0;
        break;
      end
    end
    start_v[k] = 1'b0;
    b2d = (lat >= 0 && bfirst >= 0) ? (c0 + lat - bfirst) : -1;
  endtask

  vec_t vt [9];
  int   lat, b2d, cnt0, exp_cyc, guard;

  initial begin
    vt[0] = mk(0, 2, {4{20'h10000}}, {8{20'h10000}}, {2{20'h0}}, {2{20'h40000}});
    vt[1] = mk(1, 1, 80'h1, 160'h08000, 40'h0, 40'h00001);
    vt[2] = mk(1, 1, 80'h1, 160'h07FFF, 40'h0, 40'h00000);
    vt[3] = mk(1, 1, 80'h10000, 160'hF0000, 40'h0, 40'h00000);
    vt[4] = mk(2, 1, 80'h10000, 160'hF0000, 40'h0, 40'hF0000);
    vt[5] = mk(0, 2, {4{20'h7FFFF}}, {8{20'h7FFFF}}, {2{20'h7FFFF}}, {2{20'h7FFFF}});
    vt[6] = mk(3, 1, {4{20'h7FFFF}}, {8{20'h80001}}, {20'h0, 20'h7FFFF}, 40'h80000);
    // 1*0.5 + 2*0.25 - 1*1 + 0.5*2 + bias 0.5 = 1.5
    vt[7] = mk(3, 1, {20'h08000, 20'hF0000, 20'h20000, 20'h10000},
               {{4{20'h0}}, 20'h20000, 20'h10000, 20'h04000, 20'h08000},
               {20'h0, 20'h08000}, {20'h0, 20'h18000});
    // neuron 1 weights all -1.0: -(1+2-1+0.5) = -2.5 -> ReLU clamps to 0
    vt[8] = mk(0, 2, {20'h08000, 20'hF0000, 20'h20000, 20'h10000},
               {{4{20'hF0000}}, 20'h20000, 20'h10000, 20'h04000, 20'h08000},
               {20'h0, 20'h08000}, {20'h0, 20'h18000});

    load(vt[0]);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    chk("rst_crd", crd_v[0], 0);
    chk("rst_cwr", cwr_v[0], 0);
    chk("rst_csel", csl[0], 0);
    chk("rst_caddr_rd", cra[0], 0);
    chk("rst_caddr_wr", cwa[0], 0);
    chk("rst_waddr", wa[0], 0);
    chk("rst_baddr", ba[0], 0);
    chk("rst_cdata_wr", cdat[0], 0);
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("rst_all_%0d", k),
          {busy_v[k], done_v[k], crd_v[k], cwr_v[k], csl[k], cra[k], cwa[k], wa[k], ba[k], cdat[k]}, 0);
    end

    for (int v = 0; v < 9; v++) begin
      load(vt[v]);
      cnt0 = wr_cnt[vt[v].k];
      run_pass(vt[v].k, 1'b0, lat, b2d);
      exp_cyc = vt[v].n * (nin_of(vt[v].k) + 4);
      chk($sformatf("vec%0d_writes", v), wr_cnt[vt[v].k] - cnt0, vt[v].n);
      for (int o = 0; o < vt[v].n; o++) begin
        chk($sformatf("vec%0d_data%0d", v, o), wr_dat[vt[v].k][o], vt[v].e[o]);
      end
      chk($sformatf("vec%0d_done_lat", v), lat, exp_cyc + 1);
      chk($sformatf("vec%0d_busy2done", v), b2d, exp_cyc);
      repeat (2) @(negedge clk);
    end

    // Reset during FETCH of neuron 1, then restart right after reset drops.
    load(vt[0]);
    cnt0 = wr_cnt[0];
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    guard = 0;
    while (wr_cnt[0] == cnt0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_first_write_seen", wr_cnt[0] - cnt0, 1);
    repeat (2) @(negedge clk);
    chk("abort_in_fetch", crd_v[0], 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs_reset",
        {busy_v[0], done_v[0], crd_v[0], cwr_v[0], csl[0], cra[0], cwa[0], wa[0], ba[0], cdat[0]}, 0);
    reset = 1'b0;
    run_pass(0, 1'b0, lat, b2d);
    chk("abort_restart_lat", lat, 2 * 8 + 1);
    chk("abort_total_writes", wr_cnt[0] - cnt0, 3);
    chk("abort_restart_data1", wr_dat[0][1], 20'h40000);
    repeat (2) @(negedge clk);

    // A second start while busy must not cause an extra pass.
    cnt0 = wr_cnt[0];
    run_pass(0, 1'b1, lat, b2d);
    chk("busy_start_lat", lat, 2 * 8 + 1);
    chk("busy_start_b2d", b2d, 2 * 8);
    repeat (30) @(negedge clk);
    chk("busy_start_writes", wr_cnt[0] - cnt0, 2);
    chk("busy_start_idle", busy_v[0], 0);

    chk("crd_cwr_overlap", n_ovl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
